// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch / decode / execute / memory / write-back.
// Outputs are decoded combinationally from the current state and the inputs.
// Optional feature: define MEM_TIMEOUT_EN to add a memory wait-cycle watchdog.
// The watchdog enters a sticky FAULT state after TIMEOUT_CYCLES wait cycles.
// Opcode encodings mirror the shared macro_defines.v values as local constants.

module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       link_write,
  output logic [1:0] pc_src,
  output logic [2:0] state,
  output logic       retire,
  output logic       fault
);

  localparam logic [3:0] OpLdr = 4'h4;
  localparam logic [3:0] OpStr = 4'h5;
  localparam logic [3:0] OpBeq = 4'h6;
  localparam logic [3:0] OpB   = 4'h7;
  localparam logic [3:0] OpBr  = 4'h8;
  localparam logic [3:0] OpBl  = 4'h9;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd7
  } state_e;

  state_e state_q, state_d;
  logic   mem_wait;

  assign state = state_q;

  // A memory wait is a request cycle without a completing handshake
  assign mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CntW-1:0] wait_cnt_inc;
  logic            timeout_hit;

  // Count includes the current wait cycle, so FAULT follows the TIMEOUT_CYCLES-th wait
  assign wait_cnt_inc = wait_cnt_q + CntW'(1);
  assign timeout_hit  = mem_wait && (wait_cnt_inc == CntW'(TIMEOUT_CYCLES));

  // Wait counter: advance while stalled in the same state, clear otherwise
  always_comb begin
    wait_cnt_d = '0;
    if (mem_wait && (state_d == state_q)) wait_cnt_d = wait_cnt_inc;
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        if ((opcode == OpB) || (opcode == OpBr) || (opcode == OpBl)) state_d = StFetch;
        else                                                         state_d = StExec;
      end
      StExec: begin
        if (opcode == OpBeq)                             state_d = StFetch;
        else if ((opcode == OpLdr) || (opcode == OpStr)) state_d = StMem;
        else                                             state_d = StWb;
      end
      StMem: begin
        if (mem_ready) state_d = (opcode == OpStr) ? StFetch : StWb;
      end
      StWb:     state_d = StFetch;
`ifdef MEM_TIMEOUT_EN
      StFault:  state_d = StFault;
`endif
      default:  state_d = StFetch;
    endcase
`ifdef MEM_TIMEOUT_EN
    if (timeout_hit) state_d = StFault;
`endif
  end

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    link_write = 1'b0;
    pc_src     = 2'b00;
    retire     = 1'b0;
    fault      = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        StDecode: begin
          if (opcode == OpB) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
            retire   = 1'b1;
          end else if (opcode == OpBr) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
          end else if (opcode == OpBl) begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            link_write = 1'b1;
            retire     = 1'b1;
          end
        end
        StExec: begin
          if (opcode == OpBeq) begin
            pc_write = zero;
            pc_src   = 2'b01;
            retire   = 1'b1;
          end
        end
        StMem: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OpStr);
          retire   = mem_ready && (opcode == OpStr);
        end
        StWb: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        StFault:  fault = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each instruction is expanded into a
// per-cycle script of inputs and expected outputs, then replayed against the DUT.
// Builds with or without MEM_TIMEOUT_EN.

module tb_multicycle_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned Tmo     = 3;
  localparam int          MaxWait = 2;
`else
  localparam int unsigned Tmo     = 15;
  localparam int          MaxWait = 5;
`endif

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpLdr = 4'h4;
  localparam logic [3:0] OpStr = 4'h5;
  localparam logic [3:0] OpBeq = 4'h6;
  localparam logic [3:0] OpB   = 4'h7;
  localparam logic [3:0] OpBr  = 4'h8;
  localparam logic [3:0] OpBl  = 4'h9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, link_write;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic       retire, fault;
  logic [10:0] outs;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .link_write(link_write),
    .pc_src    (pc_src),
    .state     (state),
    .retire    (retire),
    .fault     (fault)
  );

  assign outs = {mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, link_write,
                 pc_src, retire, fault};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        z;
    logic [3:0]  op;
    logic [2:0]  st;
    logic [10:0] outs;
  } cyc_t;

  cyc_t q[$];

  function automatic int rnd();
    return int'($urandom_range(0, 1));
  endfunction

  // Pack expected outputs in the same order as the observed 'outs' bus
  function automatic logic [10:0] pk(input int mreq, input int mwe, input int asel,
                                     input int irw, input int pcw, input int rw,
                                     input int lw, input int psrc, input int ret,
                                     input int flt);
    return {mreq[0], mwe[0], asel[0], irw[0], pcw[0], rw[0], lw[0], psrc[1:0], ret[0],
            flt[0]};
  endfunction

  function automatic void push(input logic [3:0] op, input int rdy, input int z,
                               input int st, input logic [10:0] o);
    cyc_t c;
    c.rdy  = rdy[0];
    c.z    = z[0];
    c.op   = op;
    c.st   = st[2:0];
    c.outs = o;
    q.push_back(c);
  endfunction

  // Script one instruction: fw fetch waits, mw data waits, z = zero flag for beq.
  // mem_ready is randomised outside request cycles since it must be ignored there.
  function automatic void gen_instr(input logic [3:0] op, input int fw, input int mw,
                                    input int z);
    int s;
    for (int i = 0; i < fw; i++) push(op, 0, rnd(), 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(op, 1, rnd(), 0, pk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    case (op)
      OpB:  begin push(op, rnd(), rnd(), 1, pk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0)); return; end
      OpBr: begin push(op, rnd(), rnd(), 1, pk(0, 0, 0, 0, 1, 0, 0, 2, 1, 0)); return; end
      OpBl: begin push(op, rnd(), rnd(), 1, pk(0, 0, 0, 0, 1, 0, 1, 1, 1, 0)); return; end
      default: push(op, rnd(), rnd(), 1, '0);
    endcase
    if (op == OpBeq) begin
      push(op, rnd(), z, 2, pk(0, 0, 0, 0, z, 0, 0, 1, 1, 0));
      return;
    end
    push(op, rnd(), rnd(), 2, '0);
    if ((op == OpLdr) || (op == OpStr)) begin
      s = (op == OpStr) ? 1 : 0;
      for (int i = 0; i < mw; i++) push(op, 0, rnd(), 3, pk(1, s, 1, 0, 0, 0, 0, 0, 0, 0));
      push(op, 1, rnd(), 3, pk(1, s, 1, 0, 0, 0, 0, 0, s, 0));
      if (s == 1) return;
    end
    push(op, rnd(), rnd(), 4, pk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
  endfunction

  // Replay up to n scripted cycles; entered and left at posedge+1
  task automatic run_q(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      zero      = c.z;
      opcode    = c.op;
      @(negedge clk);
      chk($sformatf("state op=%0d", c.op), int'(state), int'(c.st));
      chk($sformatf("outs op=%0d st=%0d", c.op, c.st), int'(outs), int'(c.outs));
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with mem_ready high (must be ignored); leaves us in the first fetch cycle
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OpAdd;
    repeat (2) @(negedge clk);
    chk("reset state", int'(state), 0);
    chk("reset outs", int'(outs), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
  endtask

  initial begin
    int exp_st[4];
    exp_st = '{0, 1, 2, 4};

    do_reset();

    // add with zero wait states: states 0,1,2,4 then back to 0
    opcode    = OpAdd;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("add state", int'(state), exp_st[i]);
      if (i == 0) chk("add ir_write c0", int'(ir_write), 1);
      if (i == 3) begin
        chk("add reg_write c3", int'(reg_write), 1);
        chk("add retire c3", int'(retire), 1);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #1;
    chk("add back to fetch", int'(state), 0);

    // Directed scripts
    gen_instr(OpLdr, 0, 2, 0);
    gen_instr(OpBeq, 1, 0, 0);
    gen_instr(OpBeq, 0, 0, 1);
    gen_instr(OpBl, 0, 0, 0);
    gen_instr(OpBr, 2, 0, 0);
    gen_instr(OpB, 0, 0, 0);
    gen_instr(OpStr, 1, 1, 0);
    gen_instr(OpStr, 0, 0, 0);
    run_q(q.size());

    // Randomised instruction stream
    for (int n = 0; n < 150; n++) begin
      gen_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, MaxWait)),
                int'($urandom_range(0, MaxWait)), rnd());
      run_q(q.size());
    end

    // Reset during a data wait: mem_req must drop at once, late ready ignored
    gen_instr(OpLdr, 0, MaxWait, 0);
    run_q(4);
    q.delete();
    mem_ready = 1'b0;
    #2;
    chk("in MEM before reset", int'(state), 3);
    rst_n = 1'b0;
    #1;
    chk("async reset mem_req", int'(mem_req), 0);
    chk("async reset state", int'(state), 0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("late ready ignored", int'(outs), 0);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("restart state", int'(state), 0);
    chk("restart mem_req", int'(mem_req), 1);
    chk("restart addr_sel", int'(addr_sel), 0);
    @(posedge clk);
    #1;
    do_reset();

    // Long memory stall
    mem_ready = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("timeout wait state", int'(state), 0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("fault state", int'(state), 7);
      chk("fault outs", int'(outs), int'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      @(posedge clk);
      #1;
    end
    do_reset();
    @(negedge clk);
    chk("post-fault state", int'(state), 0);
    chk("post-fault fault", int'(fault), 0);
    chk("post-fault mem_req", int'(mem_req), 1);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall state", int'(state), 0);
      chk("stall outs", int'(outs), int'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      @(posedge clk);
      #1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of memory wait cycles before fault (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 4, opcode field of the instruction register, using the encodings in macro_defines.v.
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory completion handshake.
REQ-007 SHALL have port mem_req, output, 1, memory access request.
REQ-008 SHALL have port mem_we, output, 1, write enable qualifying mem_req.
REQ-009 SHALL have port addr_sel, output, 1, address select: 0 = PC, 1 = ALU result.
REQ-010 SHALL have ports ir_write, pc_write, reg_write and link_write, each output, 1, a datapath write enable.
REQ-011 SHALL have port pc_src, output, 2, PC source select: 00 = PC+1, 01 = branch target, 10 = register.
REQ-012 SHALL have port state, output, 3, current state encoding.
REQ-013 SHALL have port retire, output, 1, a one-cycle pulse on instruction completion.
REQ-014 SHALL have port fault, output, 1, sticky memory-timeout flag.

Function
REQ-015 SHALL use the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and FAULT=7, and outputs SHALL be decoded combinationally from the state and inputs.
REQ-016 SHALL behave in FETCH as follows: mem_req=1, mem_we=0, addr_sel=0; on mem_ready=1, ir_write=1, pc_write=1, pc_src=00, and next state DECODE; otherwise it holds.
REQ-017 SHALL behave in DECODE as follows: for `b, pc_write=1, pc_src=01, retire=1, next FETCH; for `br, pc_write=1, pc_src=10, retire=1, next FETCH; for `bl, pc_write=1, pc_src=01, link_write=1, retire=1, next FETCH; for all other opcodes, next EXEC.
REQ-018 SHALL behave in EXEC as follows: for `beq, pc_write=zero, pc_src=01, retire=1, next FETCH; for `ldr/`str, next MEM; for all others, next WB.
REQ-019 SHALL behave in MEM as follows: mem_req=1, addr_sel=1, mem_we=1 only for `str; on mem_ready, `str gives retire=1 and next FETCH, and `ldr gives next WB.
REQ-020 SHALL behave in WB as follows: reg_write=1, retire=1, next FETCH; every ALU instruction therefore takes 4 cycles plus fetch wait.
REQ-021 SHALL hold mem_req, mem_we and addr_sel stable until the cycle in which mem_ready is sampled high.
REQ-022 SHALL ignore mem_ready while mem_req=0.
REQ-023 SHALL accept mem_ready high in the first cycle of a request, giving zero wait states.
REQ-024 SHALL keep opcode stable from DECODE until retire; the block does not latch it.
REQ-025 SHALL drive every output not named for the current state to 0.
REQ-026 SHALL treat state codes 5 and 6 as illegal: all outputs 0, next FETCH.

Reset
REQ-027 SHALL, while rst_n=0, force state to FETCH, force all outputs to 0 (including mem_req), and clear fault and the wait counter.
REQ-028 SHALL issue the first fetch request in the first cycle after rst_n deasserts.
REQ-029 SHALL, on reset asserted mid-access, drop mem_req immediately; a late mem_ready is ignored.

Configuration
REQ-030 SHALL, with MEM_TIMEOUT_EN defined, run a wait counter that increments each cycle with mem_req=1 and mem_ready=0 and clears on mem_ready or on a state change.
REQ-031 SHALL, with MEM_TIMEOUT_EN defined, enter FAULT on the wait cycle in which the counter equals TIMEOUT_CYCLES; in FAULT, fault=1, all other outputs are 0, and the block stays there until reset.
REQ-032 SHALL, with MEM_TIMEOUT_EN undefined, omit the counter, tie fault to 0, never enter FAULT, and wait indefinitely.

Verification
REQ-033 SHALL cover: `add with mem_ready always 1 -> states 0,1,2,4,0; ir_write in cycle 0; reg_write and retire in cycle 3.
REQ-034 SHALL cover: `ldr with 2-cycle data wait -> MEM held 3 cycles with addr_sel=1, mem_we=0, then WB reg_write=1.
REQ-035 SHALL cover: `beq with zero=0, then with zero=1 -> pc_write=0 then 1 in EXEC, with pc_src=01 and retire=1 both times.
REQ-036 SHALL cover: `bl -> DECODE shows pc_write=1, link_write=1, pc_src=01; next state FETCH.
REQ-037 SHALL cover: with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=3, mem_ready held 0 in FETCH -> FAULT after 3 wait cycles, fault=1 sticky, mem_req=0; rst_n pulse -> FETCH, fault=0.
REQ-038 SHALL cover: rst_n asserted during a MEM wait -> mem_req=0 in the same cycle; after release, fetch restarts with addr_sel=0.
